// File: rtl/bus_select_encoder.sv
// Registered N-source bus-select encoder with fixed-priority / round-robin arbitration,
// grant locking and no-request / multiple-request flags.
module bus_select_encoder #(
  parameter int          N            = 32,
  parameter int          W            = 5,
  parameter int unsigned DEFAULT_CODE = (32'd1 << W) - 32'd1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         mode,
  input  logic         lock,
  input  logic [N-1:0] req,
  output logic [W-1:0] sel,
  output logic         valid,
  output logic         multi,
  output logic [W-1:0] ptr
);

  generate
    if ((N < 2) || (N > 256) || ((1 << W) < N)) begin : g_bad_params
      $error("bus_select_encoder: N must be 2..256 and 2**W must be >= N");
    end
  endgenerate

  logic [W-1:0] sel_r, ptr_r;
  logic         valid_r, multi_r;
  logic [W-1:0] sel_nxt_s, ptr_nxt_s;
  logic         valid_nxt_s, multi_nxt_s;
  logic [W-1:0] fixed_idx_s, upper_idx_s, rr_idx_s, rr_ptr_s;
  logic         upper_found_s, lock_hit_s, any_s, multi_s;

  assign any_s   = |req;
  assign multi_s = |(req & (req - {{(N-1){1'b0}}, 1'b1}));

  // Scan requests: lowest set index overall, lowest set index at or above ptr, locked source still requesting
  always_comb begin
    fixed_idx_s   = {W{1'b0}};
    upper_idx_s   = {W{1'b0}};
    upper_found_s = 1'b0;
    lock_hit_s    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      fixed_idx_s   = req[i] ? W'(i) : fixed_idx_s;
      upper_idx_s   = (req[i] && (W'(i) >= ptr_r)) ? W'(i) : upper_idx_s;
      upper_found_s = upper_found_s | (req[i] & (W'(i) >= ptr_r));
      lock_hit_s    = lock_hit_s | (req[i] & (W'(i) == sel_r));
    end
  end

  // A circular search with no hit at or above ptr wraps to the lowest set index
  assign rr_idx_s = upper_found_s ? upper_idx_s : fixed_idx_s;
  assign rr_ptr_s = (rr_idx_s == W'(N - 1)) ? {W{1'b0}} : (rr_idx_s + {{(W-1){1'b0}}, 1'b1});

  // Next-state selection: hold, lock hold, no request, fixed priority or round-robin
  always_comb begin
    sel_nxt_s   = sel_r;
    valid_nxt_s = valid_r;
    multi_nxt_s = multi_r;
    ptr_nxt_s   = ptr_r;
    if (en) begin
      multi_nxt_s = multi_s;
      if (lock && valid_r && lock_hit_s) begin
        sel_nxt_s   = sel_r;
        valid_nxt_s = 1'b1;
      end else if (!any_s) begin
        sel_nxt_s   = W'(DEFAULT_CODE);
        valid_nxt_s = 1'b0;
      end else if (!mode) begin
        sel_nxt_s   = fixed_idx_s;
        valid_nxt_s = 1'b1;
      end else begin
        sel_nxt_s   = rr_idx_s;
        valid_nxt_s = 1'b1;
        ptr_nxt_s   = rr_ptr_s;
      end
    end else begin
      multi_nxt_s = multi_r;
    end
  end

  // State register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      sel_r   <= W'(DEFAULT_CODE);
      valid_r <= 1'b0;
      multi_r <= 1'b0;
      ptr_r   <= {W{1'b0}};
    end else begin
      sel_r   <= sel_nxt_s;
      valid_r <= valid_nxt_s;
      multi_r <= multi_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  assign sel   = sel_r;
  assign valid = valid_r;
  assign multi = multi_r;
  assign ptr   = ptr_r;

endmodule

// File: tb/tb_bus_select_encoder.sv
// Self-checking bench: N=32 and N=24 encoders against a behavioural model,
// plus literal expectations from the directed test plan.
module tb_bus_select_encoder;

  logic        clk = 1'b0;
  logic        clr, en, mode, lock;
  logic [31:0] req;
  logic [23:0] req24;
  logic [4:0]  sel, ptr, sel24, ptr24;
  logic        valid, multi, valid24, multi24;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [4:0] m_sel, m_ptr, m24_sel, m24_ptr;
  logic       m_valid, m_multi, m24_valid, m24_multi;

  always #5 clk = ~clk;

  bus_select_encoder #(.N(32), .W(5)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .lock(lock), .req(req),
    .sel(sel), .valid(valid), .multi(multi), .ptr(ptr)
  );

  bus_select_encoder #(.N(24), .W(5)) dut24 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .lock(lock), .req(req24),
    .sel(sel24), .valid(valid24), .multi(multi24), .ptr(ptr24)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one edge: search order written as an explicit circular walk
  task automatic model_step(input int n, input logic [31:0] r,
                            inout logic [4:0] s, inout logic v,
                            inout logic m, inout logic [4:0] p);
    bit found;
    int idx;
    found = 1'b0;
    if (clr) begin
      s = 5'd31; v = 1'b0; m = 1'b0; p = 5'd0;
    end else if (en) begin
      m = ($countones(r) > 1);
      if (lock && v && r[s]) begin
        s = s;
      end else if (r == 32'h0) begin
        s = 5'd31; v = 1'b0;
      end else if (!mode) begin
        for (int i = n - 1; i >= 0; i--) if (r[i]) s = 5'(i);
        v = 1'b1;
      end else begin
        for (int k = 0; k < n; k++) begin
          idx = (int'(p) + k) % n;
          if (!found && r[idx]) begin
            s = 5'(idx);
            found = 1'b1;
          end
        end
        v = 1'b1;
        p = 5'((int'(s) + 1) % n);
      end
    end
  endtask

  // Advance the model at each edge, then compare both DUTs once outputs settle
  always @(posedge clk) begin
    if (clr) started = 1'b1;
    if (started) begin
      model_step(32, req, m_sel, m_valid, m_multi, m_ptr);
      model_step(24, {8'h00, req24}, m24_sel, m24_valid, m24_multi, m24_ptr);
      #1;
      chk("sel",     {27'd0, sel},    {27'd0, m_sel});
      chk("valid",   {31'd0, valid},  {31'd0, m_valid});
      chk("multi",   {31'd0, multi},  {31'd0, m_multi});
      chk("ptr",     {27'd0, ptr},    {27'd0, m_ptr});
      chk("sel24",   {27'd0, sel24},  {27'd0, m24_sel});
      chk("valid24", {31'd0, valid24},{31'd0, m24_valid});
      chk("multi24", {31'd0, multi24},{31'd0, m24_multi});
      chk("ptr24",   {27'd0, ptr24},  {27'd0, m24_ptr});
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] pick_req(input int width);
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = 32'h0;
      1:       r = 32'h1 << $urandom_range(0, width - 1);
      2:       r = $urandom;
      default: r = (32'h1 << $urandom_range(0, width - 1)) | (32'h1 << $urandom_range(0, width - 1));
    endcase
    return r;
  endfunction

  initial begin
    clr = 1'b1; en = 1'b1; mode = 1'b0; lock = 1'b0; req = 32'hFFFFFFFF; req24 = 24'h0;
    tick();
    chk("rst_sel", {27'd0, sel}, 32'd31);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_multi", {31'd0, multi}, 32'd0);
    chk("rst_ptr", {27'd0, ptr}, 32'd0);
    clr = 1'b0;
    tick();
    chk("post_rst_sel", {27'd0, sel}, 32'd0);
    chk("post_rst_valid", {31'd0, valid}, 32'd1);
    chk("post_rst_multi", {31'd0, multi}, 32'd1);

    for (int i = 0; i < 32; i++) begin
      req = 32'h1 << i;
      tick();
      chk("onehot_sel", {27'd0, sel}, 32'(i));
      chk("onehot_multi", {31'd0, multi}, 32'd0);
    end
    req = 32'h0;
    tick();
    chk("zero_sel", {27'd0, sel}, 32'd31);
    chk("zero_valid", {31'd0, valid}, 32'd0);

    req = 32'h00800410; tick();
    chk("fp_sel4", {27'd0, sel}, 32'd4);
    chk("fp_multi", {31'd0, multi}, 32'd1);
    req = 32'h00800400; tick();
    chk("fp_sel10", {27'd0, sel}, 32'd10);
    en = 1'b0; req = 32'h1; tick();
    chk("en_hold", {27'd0, sel}, 32'd10);
    en = 1'b1;

    mode = 1'b1; req = 32'h80000011;
    tick(); chk("rr_sel0", {27'd0, sel}, 32'd0);  chk("rr_ptr1", {27'd0, ptr}, 32'd1);
    tick(); chk("rr_sel4", {27'd0, sel}, 32'd4);  chk("rr_ptr5", {27'd0, ptr}, 32'd5);
    tick(); chk("rr_sel31", {27'd0, sel}, 32'd31); chk("rr_ptr0", {27'd0, ptr}, 32'd0);
    tick(); chk("rr_sel0b", {27'd0, sel}, 32'd0); chk("rr_ptr1b", {27'd0, ptr}, 32'd1);

    mode = 1'b0; req = 32'h8; tick();
    chk("lk_sel3", {27'd0, sel}, 32'd3);
    lock = 1'b1; req = 32'hB; tick();
    chk("lk_hold", {27'd0, sel}, 32'd3);
    chk("lk_multi", {31'd0, multi}, 32'd1);
    req = 32'h3; tick();
    chk("lk_release", {27'd0, sel}, 32'd0);
    tick();
    clr = 1'b1; tick();
    chk("mid_rst_sel", {27'd0, sel}, 32'd31);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);

    clr = 1'b0; lock = 1'b0; mode = 1'b1; req = 32'h0; req24 = 24'h800000; tick();
    chk("n24_sel23", {27'd0, sel24}, 32'd23);
    chk("n24_wrap", {27'd0, ptr24}, 32'd0);
    req24 = 24'h000001; tick();
    chk("n24_sel0", {27'd0, sel24}, 32'd0);
    chk("n24_ptr1", {27'd0, ptr24}, 32'd1);

    for (int c = 0; c < 3000; c++) begin
      clr  = ($urandom_range(0, 63) == 0);
      en   = ($urandom_range(0, 7) != 0);
      lock = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) req = pick_req(32);
      if ($urandom_range(0, 3) == 0) req24 = 24'(pick_req(24));
      tick();
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
